// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, ir} entries with flush.
// Storage is registered; the head entry is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t din_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + AW'(1);
            if (pop_ok)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, imem requests, fetch queue and redirect.
// Define FETCH_BYPASS_EN to present a response arriving at an empty queue directly.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_8000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_ir
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic          inflight_q, inflight_d;

    logic [CW-1:0] count;
    logic          empty;
    fetch_entry_t  head, resp;
    logic          hold_off, resp_ok, bypass_sel, push, pop;

    // A response landing in a redirect or reset cycle is the squashed one.
    assign hold_off = rst || br_taken;
    assign resp_ok  = inflight_q && !hold_off;
    assign resp     = '{pc: rpc_q, ir: imem_rdata};

    assign imem_req  = !hold_off
                     && ((count + CW'(inflight_q)) < CW'(DEPTH));
    assign imem_addr = pc_q;

`ifdef FETCH_BYPASS_EN
    assign bypass_sel = empty && resp_ok;
`else
    assign bypass_sel = DISABLE;
`endif

    always_comb begin
        dec_valid = DISABLE;
        dec_pc    = '0;
        dec_ir    = NOP_INSN;
        if (!hold_off) begin
            if (!empty) begin
                dec_valid = ENABLE;
                dec_pc    = head.pc;
                dec_ir    = head.ir;
            end else if (bypass_sel) begin
                dec_valid = ENABLE;
                dec_pc    = resp.pc;
                dec_ir    = resp.ir;
            end
        end
    end

    assign push = resp_ok && !(bypass_sel && dec_ready);
    assign pop  = !hold_off && !empty && dec_ready;

    always_comb begin
        pc_d       = pc_q;
        rpc_d      = rpc_q;
        inflight_d = imem_req;
        if (br_taken) begin
            pc_d = align_pc(br_target);
        end else if (imem_req) begin
            pc_d  = pc_q + PC_STEP;
            rpc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rpc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rpc_q      <= rpc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush_i(br_taken),
        .push_i (push),
        .din_i  (resp),
        .pop_i  (pop),
        .head_o (head),
        .empty_o(empty),
        .count_o(count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: reference PC/queue model checked every cycle.
// Expected latencies follow FETCH_BYPASS_EN when it is defined.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_8000;
`ifdef FETCH_BYPASS_EN
    localparam int FETCH_LAT = 1;
    localparam int REDIR_LAT = 2;
`else
    localparam int FETCH_LAT = 2;
    localparam int REDIR_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        br_taken;
    logic [31:0] br_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_ir;
    logic [31:0] dmask;

    int ntests = 0;
    int nfail  = 0;
    int nxfer  = 0;

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .br_taken  (br_taken),
        .br_target (br_target),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_pc    (dec_pc),
        .dec_ir    (dec_ir)
    );

    always #5 clk = ~clk;

    // Synchronous imem: word is address xor a per-phase mask.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ dmask;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: next fetch PC, one outstanding response, delivery queue.
    fetch_entry_t exp_q[$];
    fetch_entry_t pend_e;
    logic         pend = 1'b0;
    logic [31:0]  exp_pc = RST_PC;

    always @(negedge clk) begin
        if (rst || br_taken) begin
            check("valid_forced_low", {31'b0, dec_valid}, 32'd0);
            check("req_forced_low", {31'b0, imem_req}, 32'd0);
            exp_q.delete();
            pend   = 1'b0;
            exp_pc = rst ? RST_PC : {br_target[31:2], 2'b00};
        end else begin
            if (pend) begin
                exp_q.push_back(pend_e);
                pend = 1'b0;
            end
            if (dec_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {31'b0, dec_valid}, 32'd0);
                end else begin
                    check("dec_pc", dec_pc, exp_q[0].pc);
                    check("dec_ir", dec_ir, exp_q[0].ir);
                    if (dec_ready) begin
                        void'(exp_q.pop_front());
                        nxfer++;
                    end
                end
            end
            if (imem_req) begin
                check("imem_addr", imem_addr, exp_pc);
                pend   = 1'b1;
                pend_e = '{pc: exp_pc, ir: exp_pc ^ dmask};
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            lat++;
            if (dec_valid) return;
        end
        lat = 99;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        @(posedge clk);
        #1;
        br_taken  = 1'b1;
        br_target = tgt;
        @(negedge clk);
        check("br_req_low", {31'b0, imem_req}, 32'd0);
        check("br_valid_low", {31'b0, dec_valid}, 32'd0);
        @(posedge clk);
        #1;
        br_taken = 1'b0;
    endtask

    initial begin
        int lat;
        int reqs;
        int n0;
        rst       = 1'b1;
        br_taken  = 1'b0;
        br_target = '0;
        dec_ready = 1'b1;
        dmask     = '0;

        // Reset state and first fetch latency.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_ir", dec_ir, NOP_INSN);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RST_PC);
        wait_valid(lat);
        check("fetch_lat", lat, FETCH_LAT);
        check("first_pc", dec_pc, RST_PC);
        check("first_ir", dec_ir, RST_PC);
        @(posedge clk);
        n0 = nxfer;
        repeat (8) @(posedge clk);
        check("throughput", nxfer - n0, 32'd8);

        // Decode stall: credit limit, hold, in-order drain.
        dmask = 32'h0BAD_0000;
        #1;
        rst       = 1'b1;
        dec_ready = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        check("stall_reqs", reqs, 32'd4);
        check("stall_valid", {31'b0, dec_valid}, 32'd1);
        check("stall_hold_pc", dec_pc, RST_PC);
        @(posedge clk);
        #1;
        dec_ready = 1'b1;
        n0 = nxfer;
        lat = 99;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req) begin
                lat = i;
                break;
            end
        end
        check("resume_addr", imem_addr, 32'h0000_8010);
        check("resume_bound", {31'b0, lat != 99}, 32'd1);
        repeat (6) @(posedge clk);
        check("drain_count", {31'b0, (nxfer - n0) >= 4}, 32'd1);

        // Redirect with a request in flight.
        redirect(32'h0000_0103);
        wait_valid(lat);
        check("redir_lat", lat, REDIR_LAT);
        check("redir_pc", dec_pc, 32'h0000_0100);
        repeat (4) @(posedge clk);

        // Redirect coinciding with a would-be transfer.
        #1;
        dec_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        dec_ready = 1'b1;
        n0 = nxfer;
        br_taken  = 1'b1;
        br_target = 32'h0000_2000;
        @(negedge clk);
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        check("br_no_xfer", nxfer - n0, 32'd0);
        wait_valid(lat);
        check("br_xfer_pc", dec_pc, 32'h0000_2000);

        // PC wrap at top of address space.
        redirect(32'hFFFF_FFFE);
        @(negedge clk);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        repeat (6) begin
            @(negedge clk);
            check("no_x", {31'b0, $isunknown({imem_req, imem_addr,
                  dec_valid, dec_pc, dec_ir})}, 32'd0);
        end

        // Reset with a full queue.
        @(posedge clk);
        #1;
        dec_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst   = 1'b1;
        dmask = 32'h5A5A_0000;
        @(negedge clk);
        check("mid_rst_valid", {31'b0, dec_valid}, 32'd0);
        check("mid_rst_ir", dec_ir, NOP_INSN);
        check("mid_rst_pc", dec_pc, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        dec_ready = 1'b1;
        @(negedge clk);
        check("post_rst_addr", imem_addr, RST_PC);
        wait_valid(lat);
        check("post_rst_pc", dec_pc, RST_PC);
        check("post_rst_ir", dec_ir, RST_PC ^ 32'h5A5A_0000);
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
